// File: rtl/gray_codec_pipe_if.sv
// Valid/ready bundle for gray_codec_pipe: request stream in, registered result stream out.
// The master modport is the producer/consumer side; the slave modport is the codec.
interface gray_codec_pipe_if #(
   parameter int unsigned WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_mode;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       out_mode;
   logic             out_err;

   modport master (
      output in_valid, in_mode, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_mode, out_err
   );

   modport slave (
      input  in_valid, in_mode, in_data, out_ready,
      output in_ready, out_valid, out_data, out_mode, out_err
   );
endinterface

// File: rtl/gray_codec_pipe.sv
// Registered Gray codec: bin->gray, gray->bin or Gray increment, chosen per transaction,
// behind a one-deep output register with full valid/ready backpressure.
module gray_codec_pipe #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   gray_codec_pipe_if.slave    bus,
   output logic [15:0]         xfer_cnt
);

   typedef enum logic [1:0] {
      ModeB2g = 2'b00,
      ModeG2b = 2'b01,
      ModeInc = 2'b10,
      ModeIll = 2'b11
   } mode_e;

   function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Prefix XOR from the MSB down.
   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b = '0;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [1:0]       out_mode_q, out_mode_d;
   logic             out_err_q, out_err_d;
   logic [15:0]      xfer_cnt_q, xfer_cnt_d;

   logic             accept;
   logic             xfer;
   logic [WIDTH-1:0] res_data;
   logic             res_err;

   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;
   assign xfer         = out_valid_q && bus.out_ready;

   always_comb begin
      res_data = bus.in_data;
      res_err  = 1'b0;
      unique case (mode_e'(bus.in_mode))
         ModeB2g: res_data = bin2gray(bus.in_data);
         ModeG2b: res_data = gray2bin(bus.in_data);
         ModeInc: res_data = bin2gray(gray2bin(bus.in_data) + WIDTH'(1));
         ModeIll: begin
            res_data = bus.in_data;
            res_err  = 1'b1;
         end
      endcase
   end

   // Accept wins over transfer, so a simultaneous pair keeps out_valid high.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_mode_d  = out_mode_q;
      out_err_d   = out_err_q;
      xfer_cnt_d  = xfer_cnt_q;
      if (xfer) begin
         out_valid_d = 1'b0;
         xfer_cnt_d  = xfer_cnt_q + 16'd1;
      end
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = res_data;
         out_mode_d  = bus.in_mode;
         out_err_d   = res_err;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_mode_q  <= 2'b00;
         out_err_q   <= 1'b0;
         xfer_cnt_q  <= 16'd0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_mode_q  <= out_mode_d;
         out_err_q   <= out_err_d;
         xfer_cnt_q  <= xfer_cnt_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_mode  = out_mode_q;
   assign bus.out_err   = out_err_q;
   assign xfer_cnt      = xfer_cnt_q;

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Directed self-checking bench for gray_codec_pipe: WIDTH=4 instance plus a WIDTH=8 spot check.
module tb_gray_codec_pipe;

   logic        clk;
   logic        rst_n;
   logic [15:0] xfer_cnt;
   logic [15:0] xfer_cnt8;
   int          n_tests;
   int          n_fail;
   logic [15:0] cnt0;

   gray_codec_pipe_if #(.WIDTH(4)) bus ();
   gray_codec_pipe_if #(.WIDTH(8)) bus8 ();

   gray_codec_pipe #(.WIDTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .xfer_cnt (xfer_cnt)
   );

   gray_codec_pipe #(.WIDTH(8)) dut8 (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus8),
      .xfer_cnt (xfer_cnt8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-computed 4-bit Gray codes for binary 0..15.
   logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic xact(input string tag, input logic [1:0] mode, input logic [3:0] data,
                       input logic [3:0] exp_data, input logic exp_err);
      bus.in_valid = 1'b1;
      bus.in_mode  = mode;
      bus.in_data  = data;
      step();
      check({tag, " valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, " data"}, 32'(bus.out_data), 32'(exp_data));
      check({tag, " mode"}, 32'(bus.out_mode), 32'(mode));
      check({tag, " err"}, 32'(bus.out_err), 32'(exp_err));
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_mode    = 2'b00;
      bus.in_data    = '0;
      bus.out_ready  = 1'b1;
      bus8.in_valid  = 1'b0;
      bus8.in_mode   = 2'b00;
      bus8.in_data   = '0;
      bus8.out_ready = 1'b1;
      step();
      step();
      check("rst out_valid", 32'(bus.out_valid), 32'd0);
      check("rst out_data", 32'(bus.out_data), 32'd0);
      check("rst out_mode", 32'(bus.out_mode), 32'd0);
      check("rst out_err", 32'(bus.out_err), 32'd0);
      check("rst xfer_cnt", 32'(xfer_cnt), 32'd0);
      check("rst in_ready", 32'(bus.in_ready), 32'd1);
      rst_n = 1'b1;

      // Exhaustive bin->gray sweep at full throughput.
      for (int i = 0; i < 16; i++) begin
         bus.in_valid = 1'b1;
         bus.in_mode  = 2'b00;
         bus.in_data  = 4'(i);
         step();
         check($sformatf("sweep valid %0d", i), 32'(bus.out_valid), 32'd1);
         check($sformatf("sweep data %0d", i), 32'(bus.out_data), 32'(gray_tab[i]));
      end
      bus.in_valid = 1'b0;
      step();
      check("sweep xfer_cnt", 32'(xfer_cnt), 32'd16);
      check("sweep drained", 32'(bus.out_valid), 32'd0);

      // gray->bin directed, then round-trip of the whole table.
      xact("g2b F", 2'b01, 4'hF, 4'hA, 1'b0);
      xact("g2b 8", 2'b01, 4'h8, 4'hF, 1'b0);
      xact("g2b 0", 2'b01, 4'h0, 4'h0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         bus.in_valid = 1'b1;
         bus.in_mode  = 2'b01;
         bus.in_data  = gray_tab[i];
         step();
         check($sformatf("roundtrip %0d", i), 32'(bus.out_data), 32'(i));
      end

      // Gray increment including wrap.
      xact("inc 0", 2'b10, 4'h0, 4'h1, 1'b0);
      xact("inc 2", 2'b10, 4'h2, 4'h6, 1'b0);
      xact("inc wrap", 2'b10, 4'h8, 4'h0, 1'b0);
      bus.in_valid = 1'b0;
      step();

      // Backpressure: 0x5 held as 0x7 while 0x9 waits.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_mode   = 2'b00;
      bus.in_data   = 4'h5;
      step();
      bus.in_data = 4'h9;
      cnt0 = xfer_cnt;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp in_ready", 32'(bus.in_ready), 32'd0);
         step();
         check("bp hold data", 32'(bus.out_data), 32'h7);
         check("bp hold valid", 32'(bus.out_valid), 32'd1);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp release in_ready", 32'(bus.in_ready), 32'd1);
      step();
      check("bp next data", 32'(bus.out_data), 32'hD);
      check("bp no bubble", 32'(bus.out_valid), 32'd1);
      check("bp cnt", 32'(xfer_cnt), 32'(cnt0 + 16'd1));
      bus.in_valid = 1'b0;
      step();
      check("bp cnt drain", 32'(xfer_cnt), 32'(cnt0 + 16'd2));

      // Illegal mode passes data through with err set.
      cnt0 = xfer_cnt;
      xact("illegal", 2'b11, 4'hA, 4'hA, 1'b1);
      bus.in_valid = 1'b0;
      step();
      check("illegal cnt", 32'(xfer_cnt), 32'(cnt0 + 16'd1));
      check("illegal drained", 32'(bus.out_valid), 32'd0);

      // Reset in the middle of a stall.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.in_mode  = 2'b00;
         bus.in_data  = 4'(i + 1);
         step();
      end
      bus.in_valid = 1'b0;
      step();
      check("pre-rst cnt", 32'(xfer_cnt), 32'd5);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 4'h3;
      step();
      check("pre-rst valid", 32'(bus.out_valid), 32'd1);
      bus.in_data = 4'h6;
      rst_n = 1'b0;
      step();
      check("mid-rst valid", 32'(bus.out_valid), 32'd0);
      check("mid-rst data", 32'(bus.out_data), 32'd0);
      check("mid-rst cnt", 32'(xfer_cnt), 32'd0);
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
      step();
      check("post-rst in_ready", 32'(bus.in_ready), 32'd1);
      check("post-rst valid", 32'(bus.out_valid), 32'd0);

      // WIDTH=8 spot check.
      bus8.in_valid = 1'b1;
      bus8.in_mode  = 2'b00;
      bus8.in_data  = 8'hFF;
      step();
      check("w8 b2g", 32'(bus8.out_data), 32'h80);
      bus8.in_mode = 2'b10;
      bus8.in_data = 8'h80;
      step();
      check("w8 inc wrap", 32'(bus8.out_data), 32'h00);
      check("w8 err", 32'(bus8.out_err), 32'd0);
      bus8.in_valid = 1'b0;
      step();
      check("w8 cnt", 32'(xfer_cnt8), 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
